// File: rtl/hack_boot_pkg.sv
// Shared constants for the Hack boot sequencer: widths, FSM state encoding
// and the order in which fields appear in the incoming image stream.
package hack_boot_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;
  localparam int LEN_W  = 16;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LEN_HI = 4'd1;
  localparam logic [3:0] S_LEN_LO = 4'd2;
  localparam logic [3:0] S_DAT_HI = 4'd3;
  localparam logic [3:0] S_DAT_LO = 4'd4;
  localparam logic [3:0] S_CSUM   = 4'd5;
  localparam logic [3:0] S_HOLD   = 4'd6;
  localparam logic [3:0] S_RUN    = 4'd7;
  localparam logic [3:0] S_ERR    = 4'd8;

  // Stream layout: length field, then word pairs, then one checksum byte.
  localparam logic [3:0] FIELD_FIRST = S_LEN_HI;
  localparam logic [3:0] FIELD_WORD  = S_DAT_HI;
  localparam logic [3:0] FIELD_LAST  = S_CSUM;

  function automatic logic is_rx_state(input logic [3:0] s);
    return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DAT_HI) ||
           (s == S_DAT_LO) || (s == S_CSUM);
  endfunction

  function automatic logic is_busy_state(input logic [3:0] s);
    return (s >= S_LEN_HI) && (s <= S_HOLD);
  endfunction

endpackage

// File: rtl/hack_boot_ctrl_word_asm.sv
// Byte-pair to 16-bit word assembler with a running mod-256 checksum of
// every accepted data byte.
module boot_word_asm
  import hack_boot_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              accept,
  input  logic              hi_lo,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word,
  output logic [BYTE_W-1:0] checksum
);

  logic [BYTE_W-1:0] hi_q, hi_d;
  logic [BYTE_W-1:0] sum_q, sum_d;

  always_comb begin
    hi_d  = hi_q;
    sum_d = sum_q;
    if (clear) begin
      sum_d = '0;
    end else if (accept) begin
      sum_d = sum_q + byte_in;
      if (hi_lo) hi_d = byte_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= '0;
      sum_q <= '0;
    end else begin
      hi_q  <= hi_d;
      sum_q <= sum_d;
    end
  end

  // The low byte is taken straight from the input so the word is ready on the accept edge.
  assign word     = {hi_q, byte_in};
  assign checksum = sum_q;

endmodule

// File: rtl/hack_boot_ctrl.sv
// Hack CPU boot sequencer: receives a length-prefixed image over a byte
// handshake, writes it into instruction ROM, checks it, then releases the CPU.
module hack_boot_ctrl
  import hack_boot_pkg::*;
#(
  parameter int ROM_AW     = 15,
  parameter int RESET_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              start,
  output logic              rom_we,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [WORD_W-1:0] rom_wdata,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W  = ROM_AW + 1;
  localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [LEN_W:0] MAX_LEN = (LEN_W + 1)'(1) << ROM_AW;

  logic [3:0]        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              rom_we_q, rom_we_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic [WORD_W-1:0] rom_wdata_q, rom_wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              accept;
  logic [LEN_W:0]    len_full;
  logic [LEN_W:0]    cnt_inc;
  logic [WORD_W-1:0] asm_word;
  logic [BYTE_W-1:0] asm_sum;

  assign rx_ready = is_rx_state(state_q);
  assign accept   = rx_valid && rx_ready;
  assign len_full = {1'b0, len_q[LEN_W-1:BYTE_W], rx_data};
  assign cnt_inc  = (LEN_W + 1)'(cnt_q) + (LEN_W + 1)'(1);

  boot_word_asm u_asm (
    .clk      (clk),
    .rst_n    (reset),
    .clear    (state_q == S_IDLE),
    .accept   (accept && ((state_q == S_DAT_HI) || (state_q == S_DAT_LO))),
    .hi_lo    (state_q == S_DAT_HI),
    .byte_in  (rx_data),
    .word     (asm_word),
    .checksum (asm_sum)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    rom_we_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    rom_wdata_d = rom_wdata_q;
    case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        state_d = FIELD_FIRST;
      end
      S_LEN_HI: if (accept) begin
        len_d   = {rx_data, len_q[BYTE_W-1:0]};
        state_d = S_LEN_LO;
      end
      S_LEN_LO: if (accept) begin
        len_d   = {len_q[LEN_W-1:BYTE_W], rx_data};
        state_d = ((len_full == '0) || (len_full > MAX_LEN)) ? S_ERR : FIELD_WORD;
      end
      S_DAT_HI: if (accept) state_d = S_DAT_LO;
      S_DAT_LO: if (accept) begin
        rom_we_d    = 1'b1;
        rom_addr_d  = cnt_q[ROM_AW-1:0];
        rom_wdata_d = asm_word;
        cnt_d       = cnt_q + CNT_W'(1);
        state_d     = (cnt_inc == {1'b0, len_q}) ? FIELD_LAST : FIELD_WORD;
      end
      S_CSUM: if (accept) begin
        hold_d  = '0;
        state_d = (rx_data == asm_sum) ? S_HOLD : S_ERR;
      end
      S_HOLD: begin
        if (hold_q == HOLD_W'(RESET_HOLD - 1)) state_d = S_RUN;
        else                                   hold_d  = hold_q + HOLD_W'(1);
      end
      S_RUN:   if (start) state_d = S_IDLE;
      S_ERR:   if (start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so cpu_reset never glitches.
  always_comb begin
    cpu_reset_d = (state_d != S_RUN);
    busy_d      = is_busy_state(state_d);
    done_d      = (state_d == S_RUN);
    err_d       = (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      rom_we_q    <= 1'b0;
      rom_addr_q  <= '0;
      rom_wdata_q <= '0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      rom_we_q    <= rom_we_d;
      rom_addr_q  <= rom_addr_d;
      rom_wdata_q <= rom_wdata_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign rom_we    = rom_we_q;
  assign rom_addr  = rom_addr_q;
  assign rom_wdata = rom_wdata_q;
  assign cpu_reset = cpu_reset_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: doc/hack_boot_ctrl.md
Name: hack_boot_ctrl

Overview:
- Boot sequencer for the Hack CPU.
- Holds the CPU in reset and receives a program image as a byte stream over a valid/ready handshake.
- Writes the image word-by-word into instruction ROM, verifies a checksum, then releases CPU reset.
- Sits between the host/serial front-end, the instruction ROM write port and the CPU `reset` input.

Parameters:
- ROM_AW, 15, ROM address width in words; maximum image length is 2^ROM_AW words.
- RESET_HOLD, 4, cycles `cpu_reset` stays high after a successful load before release (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset for this block.
- rx_data  in  8  incoming image byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  block accepts a byte this cycle.
- start  in  1  single-cycle reload request.
- rom_we  out  1  ROM write strobe, one cycle per word.
- rom_addr  out  ROM_AW  ROM word address.
- rom_wdata  out  16  ROM write data.
- cpu_reset  out  1  active-high reset to the CPU.
- busy  out  1  load in progress.
- done  out  1  image loaded and CPU running.
- err  out  1  load failed; CPU held in reset.

Behaviour:
- Reset values (while `reset`=0):
  - state=IDLE; rx_ready=0, rom_we=0, rom_addr=0, rom_wdata=0.
  - cpu_reset=1, busy=0, done=0, err=0.
  - Word counter=0, length=0, checksum=0.
- Byte transfer: a byte is accepted on a rising edge with rx_valid&rx_ready. rx_ready is a pure decode of state: 1 in LEN_HI, LEN_LO, DAT_HI, DAT_LO and CSUM; 0 elsewhere. rx_valid without rx_ready is ignored; the sender holds its byte.
- Stream format, big-endian:
  - N[15:8], N[7:0]: length in words.
  - N words, each sent as hi byte then lo byte.
  - One checksum byte = sum mod 256 of the 2N data bytes. Length bytes are excluded.
- FSM:
  - IDLE: one cycle after reset release go to LEN_HI. Clear counter and checksum.
  - LEN_HI: accept byte → len[15:8]; go to LEN_LO.
  - LEN_LO: accept byte → len[7:0]. If N==0 or N>2^ROM_AW → ERR, else → DAT_HI.
  - DAT_HI: accept byte → hi register; checksum += byte; go to DAT_LO.
  - DAT_LO: accept byte; checksum += byte. Next cycle drive rom_we=1 for exactly one cycle, with rom_addr=counter[ROM_AW-1:0] and rom_wdata={hi,byte}. Increment counter. Go to DAT_HI, or to CSUM when counter+1==N.
  - CSUM: accept byte. Equal to checksum → HOLD; mismatch → ERR.
  - HOLD: cpu_reset=1; count RESET_HOLD cycles, then → RUN.
  - RUN: cpu_reset=0, done=1. A start pulse → IDLE; cpu_reset is registered high the next edge, done clears.
  - ERR: err=1, cpu_reset=1. A start pulse → IDLE; err clears.
- start in any other state is ignored.
- busy=1 in LEN_HI..HOLD.
- Addresses always begin at 0 and increment by 1. Counter width is ROM_AW+1, so N=2^ROM_AW completes without wrap; the last word is written at address 2^ROM_AW-1.
- The word write pulse and acceptance of the next hi byte may coincide; no bubble is required.
- Reset asserted mid-load: immediate return to reset values. The partially written ROM is not cleared. cpu_reset stays 1.
- cpu_reset is registered: glitch-free, never low before the HOLD count has expired.

Decomposition:
- Package hack_boot_pkg holds:
  - FSM state encoding (IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, CSUM, HOLD, RUN, ERR).
  - Byte/word width constants.
  - Stream field order constants.
- One sub-module, boot_word_asm: byte-pair to 16-bit word assembler plus running 8-bit checksum. Controlled by accept/hi_lo/clear inputs.
- FSM, counters and hold timer stay in hack_boot_ctrl.

Test Plan:
- Nominal load: stream 00 02 30 39 EC 10 65, rx_valid always 1. Required response:
  - rom_we pulses twice: addr0=0x3039, addr1=0xEC10.
  - cpu_reset falls exactly RESET_HOLD cycles after the CSUM byte.
  - done=1, err=0.
- Bad checksum: same stream with last byte 66. Required response: 2 ROM writes, then err=1, cpu_reset stays 1, done=0. A start pulse returns to LEN_HI with err=0.
- Length errors:
  - N=0x0000 → err=1 right after the 2nd byte, no rom_we.
  - N=0x8001 with ROM_AW=15 → same.
  - N=0x8000 with ROM_AW=15 → accepted; last write at addr 0x7FFF.
- Handshake gaps: rx_valid toggled randomly. Required response: identical ROM contents and sequence as the nominal load; no byte duplicated or dropped.
- Reload from RUN: start pulse. Required response: cpu_reset=1 on the next edge, done=0; a new image overwrites from addr 0.
- Async reset mid-image: reset low after the 3rd byte, off-clock-edge. Required response: outputs take reset values immediately; after release a full image loads correctly from address 0.
